// File: rtl/addr_sweep_pkg.sv
// rtl/addr_sweep_pkg.sv - shared types and constants for the address sweep scheduler
package addr_sweep_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest legal sweep length (buffer depth)
    localparam int MAX_LEN_DEF = 100;

    // Requester indices
    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage

// File: rtl/addr_cnt.sv
// rtl/addr_cnt.sv - up-counter with enable and synchronous clear
module addr_cnt #(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Clear wins over enable so a sweep can end and restart from 0 cleanly
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/addr_sweep_sched.sv
// rtl/addr_sweep_sched.sv - round-robin shared address sweep scheduler (optional SWEEP_PERF_EN stall counter)
module addr_sweep_sched
    import addr_sweep_pkg::*;
#(
    parameter int CNT_WIDTH = 7,
    parameter int MAX_LEN   = MAX_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_i,
    input  logic [CNT_WIDTH-1:0] len0_i,
    input  logic [CNT_WIDTH-1:0] len1_i,
    input  logic                 stall_i,
    output logic [1:0]           gnt_o,
    output logic [CNT_WIDTH-1:0] addr_o,
    output logic                 addr_vld_o,
    output logic [1:0]           done_o,
    output logic                 busy_o
`ifdef SWEEP_PERF_EN
    ,
    output logic [15:0]          stall_cnt_o
`endif
);

    localparam logic [CNT_WIDTH-1:0] MAX_LEN_C = CNT_WIDTH'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 ptr_q, ptr_d;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] len0_eff, len1_eff, len_sel, len_last;
    logic                 win;
    logic                 grant_now;
    logic                 owner_req;
    logic                 run_vld;

    // Clamp requested lengths to the buffer depth and pick the arbitration winner
    always_comb begin
        len0_eff = (len0_i > MAX_LEN_C) ? MAX_LEN_C : len0_i;
        len1_eff = (len1_i > MAX_LEN_C) ? MAX_LEN_C : len1_i;
        win      = 1'(REQ0);
        if (req_i == 2'b10) begin
            win = 1'(REQ1);
        end else if (req_i == 2'b11) begin
            win = ptr_q;
        end
        len_sel   = win ? len1_eff : len0_eff;
        grant_now = (state_q == ST_IDLE) && (|req_i);
        owner_req = |(req_i & gnt_q);
        len_last  = len_q - ONE_C;
    end

    assign run_vld = (state_q == ST_RUN) && !stall_i;

    // State register: FSM state, captured grant/length and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            len_q   <= '0;
            ptr_q   <= 1'(REQ0);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: grant in IDLE, sweep/abort in RUN, single-cycle DONE
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    gnt_d   = 2'b01 << win;
                    len_d   = len_sel;
                    state_d = (len_sel == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort takes priority: a dropped request never gets a done pulse
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (run_vld && (cnt == len_last)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Any grant ending (done or abort) hands priority to the other side
        if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
            ptr_d = ~ptr_q;
            gnt_d = 2'b00;
        end
    end

    // Output decode from the current state
    always_comb begin
        gnt_o      = 2'b00;
        addr_vld_o = 1'b0;
        done_o     = 2'b00;
        busy_o     = (state_q != ST_IDLE);
        case (state_q)
            ST_RUN: begin
                gnt_o      = gnt_q;
                addr_vld_o = !stall_i;
            end
            ST_DONE: begin
                done_o = gnt_q;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

    // Counter runs only while sweeping; it is held at 0 outside RUN
    addr_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (run_vld),
        .clr_i (state_d != ST_RUN),
        .cnt_o (cnt)
    );

    assign addr_o = cnt;

`ifdef SWEEP_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled RUN cycles, restarted at each grant
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (grant_now) begin
            stall_cnt_d = 16'h0000;
        end else if ((state_q == ST_RUN) && stall_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_addr_sweep_sched.sv
// tb/tb_addr_sweep_sched.sv - self-checking bench for addr_sweep_sched
module tb_addr_sweep_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_i;
    logic [6:0] len0_i, len1_i;
    logic       stall_i;
    logic [1:0] gnt_o;
    logic [6:0] addr_o;
    logic       addr_vld_o;
    logic [1:0] done_o;
    logic       busy_o;
`ifdef SWEEP_PERF_EN
    logic [15:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    addr_sweep_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .len0_i     (len0_i),
        .len1_i     (len1_i),
        .stall_i    (stall_i),
        .gnt_o      (gnt_o),
        .addr_o     (addr_o),
        .addr_vld_o (addr_vld_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
`ifdef SWEEP_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: who owns the sweep, next address, target length,
    // which requester is owed a done pulse, and who has priority.
    int m_owner = -1;
    int m_pos   = 0;
    int m_total = 0;
    int m_fin   = -1;
    int m_ptr   = 0;

    logic [12:0] exp_vec;
    wire  [12:0] dut_vec = {gnt_o, addr_o, addr_vld_o, done_o, busy_o};

    // Drive one cycle of inputs, derive expected outputs, then advance the model
    task automatic step(input logic r, input logic [1:0] rq, input logic [6:0] a,
                        input logic [6:0] b, input logic st);
        logic [1:0] e_gnt, e_done;
        logic [6:0] e_addr;
        logic       e_vld, e_busy;
        int         w, l;
        @(negedge clk);
        rst = r; req_i = rq; len0_i = a; len1_i = b; stall_i = st;
        #1;
        e_gnt = 0; e_done = 0; e_addr = 0; e_vld = 0; e_busy = 0;
        if (m_fin >= 0) begin
            e_done = (m_fin == 0) ? 2'b01 : 2'b10;
            e_busy = 1;
        end else if (m_owner >= 0) begin
            e_gnt  = (m_owner == 0) ? 2'b01 : 2'b10;
            e_addr = 7'(m_pos);
            e_vld  = !st;
            e_busy = 1;
        end
        exp_vec = {e_gnt, e_addr, e_vld, e_done, e_busy};
        if (r) begin
            m_owner = -1; m_fin = -1; m_pos = 0; m_ptr = 0;
        end else if (m_fin >= 0) begin
            m_fin = -1; m_ptr = 1 - m_ptr;
        end else if (m_owner >= 0) begin
            if (!rq[m_owner]) begin
                m_owner = -1; m_ptr = 1 - m_ptr;
            end else if (!st) begin
                if (m_pos == m_total - 1) begin
                    m_fin = m_owner; m_owner = -1;
                end else begin
                    m_pos++;
                end
            end
        end else if (rq != 2'b00) begin
            w = (rq == 2'b11) ? m_ptr : ((rq == 2'b01) ? 0 : 1);
            l = (w == 1) ? int'(b) : int'(a);
            if (l > 100) l = 100;
            if (l == 0) begin
                m_fin = w;
            end else begin
                m_owner = w; m_pos = 0; m_total = l;
            end
        end
    endtask

    task automatic test_reset();
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b11, 5, 5, 0);
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL reset_model got %h exp %h", dut_vec, exp_vec);
        end
        step(0, 2'b00, 0, 0, 0);
        checks++;
        if (dut_vec !== 13'h0) begin
            errors++; $display("FAIL reset_zero got %h exp 0", dut_vec);
        end
    endtask

    task automatic test_single();
        int nv = 0;
        bit seen = 0;
        step(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 2'b01, 5, 0, 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL single cyc%0d got %h exp %h", i, dut_vec, exp_vec);
            end
            if (addr_vld_o) nv++;
            if (done_o == 2'b01) seen = 1;
        end
        checks++;
        if (!seen || nv != 5) begin
            errors++; $display("FAIL single_count got vld=%0d done=%0d exp vld=5 done=1", nv, seen);
        end
        step(0, 2'b00, 5, 0, 0);
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL single_idle got %h exp %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_both();
        logic [1:0] rq = 2'b11;
        logic [1:0] order [2];
        int nd = 0;
        int gap = 0;
        step(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 30 && nd < 2; i++) begin
            step(0, rq, 3, 2, 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL both cyc%0d got %h exp %h", i, dut_vec, exp_vec);
            end
            if (nd == 1 && !busy_o) gap++;
            if (done_o != 2'b00) begin
                order[nd] = done_o;
                nd++;
                rq = rq & ~done_o;
            end
        end
        checks++;
        if (nd != 2 || order[0] !== 2'b01 || order[1] !== 2'b10 || gap != 1) begin
            errors++;
            $display("FAIL both_order got n=%0d %b %b gap=%0d exp n=2 01 10 gap=1", nd, order[0], order[1], gap);
        end
    endtask

    task automatic test_stall();
        int ns = 0;
        int ng = 0;
        bit seen = 0;
        logic st;
        step(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 20 && !seen; i++) begin
            st = (m_owner == 0 && m_pos == 2 && ns < 2);
            if (st) ns++;
            step(0, 2'b01, 4, 0, st);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL stall cyc%0d got %h exp %h", i, dut_vec, exp_vec);
            end
            if (gnt_o != 2'b00) ng++;
            if (done_o != 2'b00) seen = 1;
        end
        checks++;
        if (!seen || ng != 6) begin
            errors++; $display("FAIL stall_len got gnt_cycles=%0d done=%0d exp 6 1", ng, seen);
        end
    endtask

    task automatic test_zero();
        step(1, 2'b00, 0, 0, 0);
        step(0, 2'b10, 9, 0, 0);
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL zero_req got %h exp %h", dut_vec, exp_vec);
        end
        step(0, 2'b10, 9, 0, 0);
        checks++;
        if (done_o !== 2'b10 || gnt_o !== 2'b00 || addr_vld_o !== 1'b0) begin
            errors++; $display("FAIL zero_done got done=%b gnt=%b vld=%b exp 10 00 0", done_o, gnt_o, addr_vld_o);
        end
        step(0, 2'b00, 9, 0, 0);
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL zero_idle got %h exp %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_clamp();
        int nv = 0;
        int last = -1;
        bit seen = 0;
        step(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 130 && !seen; i++) begin
            step(0, 2'b01, 120, 0, 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL clamp cyc%0d got %h exp %h", i, dut_vec, exp_vec);
            end
            if (addr_vld_o) begin nv++; last = int'(addr_o); end
            if (done_o != 2'b00) seen = 1;
        end
        checks++;
        if (!seen || nv != 100 || last != 99) begin
            errors++; $display("FAIL clamp_count got n=%0d last=%0d done=%0d exp 100 99 1", nv, last, seen);
        end
    endtask

    task automatic test_abort();
        step(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (m_owner == 0 && m_pos == 6) break;
            step(0, 2'b01, 50, 9, 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL abort_run cyc%0d got %h exp %h", i, dut_vec, exp_vec);
            end
        end
        step(0, 2'b00, 50, 9, 0);
        checks++;
        if (addr_o !== 7'd6 || done_o !== 2'b00) begin
            errors++; $display("FAIL abort_at6 got addr=%0d done=%b exp 6 00", addr_o, done_o);
        end
        step(0, 2'b00, 50, 9, 0);
        checks++;
        if (dut_vec !== 13'h0) begin
            errors++; $display("FAIL abort_idle got %h exp 0", dut_vec);
        end
        step(0, 2'b11, 50, 9, 0);
        step(0, 2'b11, 50, 9, 0);
        checks++;
        if (gnt_o !== 2'b10 || dut_vec !== exp_vec) begin
            errors++; $display("FAIL abort_rr got %h exp gnt=10 vec %h", dut_vec, exp_vec);
        end
        step(0, 2'b11, 50, 9, 0);
        step(1, 2'b11, 50, 9, 0);
        step(0, 2'b00, 50, 9, 0);
        checks++;
        if (dut_vec !== 13'h0 || dut_vec !== exp_vec) begin
            errors++; $display("FAIL abort_rst got %h exp 0", dut_vec);
        end
    endtask

    task automatic test_random();
        logic [1:0] rq = 2'b00;
        logic [6:0] a = 0, b = 0;
        logic       st, r;
        step(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) rq[0] = ~rq[0];
            if ($urandom_range(0, 11) == 0) rq[1] = ~rq[1];
            if ($urandom_range(0, 3) == 0)
                a = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0)
                b = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 12));
            st = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(r, rq, a, b, st);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random cyc%0d got %h exp %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 2'b00; len0_i = 0; len1_i = 0; stall_i = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_stall();
        test_zero();
        test_clamp();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_sweep_sched.md
Name: addr_sweep_sched

Overview:
- Schedules a single shared address counter between two requesters. Each requester asks for a linear sweep of addresses 0..len-1 over the 100-entry buffer.
- A round-robin arbiter grants one requester at a time. An FSM drives the counter enable and clear and emits one address per accepted cycle.
- Sits between the requesting engines and the buffer address port, replacing a free-running counter with a sequenced, shared one.

Parameters:
- CNT_WIDTH, 7, address/counter width (2^7 = 128 covers the 100-entry address space).
- MAX_LEN, 100, largest legal sweep length; larger requested lengths are clamped to this value.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  2  per-requester sweep request level; held until done or abort.
- len0_i  in  CNT_WIDTH  sweep length for requester 0; sampled at grant.
- len1_i  in  CNT_WIDTH  sweep length for requester 1; sampled at grant.
- stall_i  in  1  downstream not ready; freezes the address while high.
- gnt_o  out  2  one-hot grant, held for the whole sweep.
- addr_o  out  CNT_WIDTH  current sweep address.
- addr_vld_o  out  1  addr_o is valid this cycle.
- done_o  out  2  one-cycle completion pulse to the granted requester.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: rst=1 at a clock edge forces:
  - FSM to IDLE;
  - gnt_o, done_o, addr_vld_o, busy_o = 0;
  - addr_o = 0;
  - round-robin pointer = requester 0 has priority.
  - Reset mid-sweep aborts silently: no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Any req_i bit high -> grant the winner next cycle and go to RUN.
  - The effective length is captured at grant: min(lenX_i, MAX_LEN).
  - The counter is cleared to 0.
- Arbitration:
  - Only one bit set -> that requester wins.
  - Both bits set -> the pointer side wins.
  - The pointer flips to the other requester after every grant ends, whether by done or abort.
- RUN:
  - addr_vld_o = !stall_i.
  - Counter increments only when addr_vld_o is high; stall_i holds addr_o.
  - When addr_o == len-1 and addr_vld_o is high -> go to DONE.
- Zero length: IDLE goes straight to DONE. addr_vld_o is never asserted, but done still pulses.
- DONE:
  - done_o[granted] = 1 for exactly one cycle.
  - gnt_o drops in the same cycle.
  - Next state is IDLE. Re-arbitration happens in IDLE, so there is a minimum one idle cycle between grants.
- Abort: granted req_i drops during RUN -> next cycle goes to IDLE.
  - gnt_o and addr_vld_o go low.
  - No done pulse.
  - Counter is cleared.
  - Pointer flips.
- Latency:
  - req_i high in IDLE -> gnt_o high on the next edge.
  - First addr_vld_o is in that same cycle (address 0).
  - Sweep length N with no stalls: done pulses N+1 cycles after the grant.
- Counter arithmetic:
  - Unsigned, CNT_WIDTH wide.
  - It never exceeds MAX_LEN-1, so no wrap is possible.
  - len values from 101 to 127 clamp to 100.
- The ungranted requester's len input and req level are ignored during RUN.

Optional Feature:
- Macro: SWEEP_PERF_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles in RUN with stall_i high.
  - Saturates at 0xFFFF.
  - Cleared by rst and at each new grant.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package addr_sweep_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - MAX_LEN default;
  - requester-index constants.
- One sub-module, addr_cnt:
  - CNT_WIDTH up-counter with en and sync clear;
  - synchronous active-high rst;
  - output is the count.
- Arbitration, FSM and clamping stay in addr_sweep_sched.

Test Plan:
- req_i=01, len0=5, no stall -> gnt_o=01 next cycle; addr_o 0,1,2,3,4 with addr_vld_o=1; done_o=01 one cycle later; gnt_o=00; then IDLE.
- req_i=11 from reset, len0=3, len1=2 -> req0 served first; after its done plus one idle cycle, req1 gets gnt_o=10 and addresses 0,1.
- len0=4, stall_i high for 2 cycles while addr_o=2 -> addr_o holds 2 with addr_vld_o=0; sweep resumes at 3; done delayed by 2 cycles.
- len1=0 -> grant, no addr_vld_o, done_o=10 one cycle after the grant.
- len0=120 -> exactly 100 valid addresses, 0..99; done pulses after addr 99.
- req0 drops at addr_o=6 of len 50 -> no done; back to IDLE; with req_i=11 afterwards, req1 wins. rst asserted mid-sweep -> all outputs 0 on the next edge.
